// File: rtl/ad9945_pkg.sv
// Shared constants for the AD9945 serial-port receiver: register map,
// shadow register widths and the frame FSM state encoding.
package ad9945_pkg;

   localparam int ADDR_OPER  = 0;
   localparam int ADDR_CTRL  = 1;
   localparam int ADDR_CLAMP = 2;
   localparam int ADDR_VGA   = 3;

   localparam int OPER_W  = 7;
   localparam int CTRL_W  = 7;
   localparam int CLAMP_W = 8;
   localparam int VGA_W   = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin, followed by single-cycle
// rise/fall pulses taken from the synchronised level.
module sync_edge_det #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic sys_clk,
   input  logic resetn,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign rise = chain[STAGES-1] & ~prev;
   assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/ad9945_spi_rx.sv
// AD9945 3-wire configuration port receiver: oversamples SL/SCK/SDATA,
// assembles LSB-first frames and updates shadow control registers.
module ad9945_spi_rx
   import ad9945_pkg::*;
#(
   parameter int                 ADDR_W      = 3,
   parameter int                 DATA_W      = 12,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [OPER_W-1:0]  OPER_RST    = 7'h00,
   parameter logic [CTRL_W-1:0]  CTRL_RST    = 7'h00,
   parameter logic [CLAMP_W-1:0] CLAMP_RST   = 8'h00,
   parameter logic [VGA_W-1:0]   VGA_RST     = 10'h000
) (
   input  logic               sys_clk,
   input  logic               resetn,
   input  logic               SCK,
   input  logic               SL,
   input  logic               SDATA,
   output logic [OPER_W-1:0]  oper,
   output logic [CTRL_W-1:0]  ctrl,
   output logic [CLAMP_W-1:0] clamp,
   output logic [VGA_W-1:0]   vga_gain,
   output logic               wr_valid,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [DATA_W-1:0]  wr_data,
   output logic               frame_err,
   output logic [15:0]        frame_cnt
);

   localparam int FRAME_W = ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

   state_t               state, next_state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [FRAME_W-1:0]   shift_q;
   logic [SYNC_STAGES-1:0] sdata_sync;
   logic                 sdata_s;
   logic                 sck_rise, unused_sck_fall;
   logic                 sl_rise, sl_fall;
   logic [ADDR_W-1:0]    frame_addr;
   logic [DATA_W-1:0]    frame_data;

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .sys_clk (sys_clk),
      .resetn  (resetn),
      .din     (SCK),
      .rise    (sck_rise),
      .fall    (unused_sck_fall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sl_sync (
      .sys_clk (sys_clk),
      .resetn  (resetn),
      .din     (SL),
      .rise    (sl_rise),
      .fall    (sl_fall)
   );

   // SDATA only needs the same delay as SCK so it lines up with sck_rise.
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) sdata_sync <= '0;
      else         sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], SDATA};
   end
   assign sdata_s = sdata_sync[SYNC_STAGES-1];

   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   // NOTE: next_state gets its default first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sl_fall) next_state = SHIFT;
         SHIFT:   if (sl_rise) next_state = CHECK;
         CHECK:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Bits arrive LSB-first; after exactly FRAME_W shifts bit k sits at position k.
   assign frame_addr = shift_q[ADDR_W-1:0];
   assign frame_data = shift_q[FRAME_W-1:ADDR_W];

   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         bit_cnt   <= '0;
         shift_q   <= '0;
         wr_valid  <= 1'b0;
         frame_err <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_cnt <= '0;
         oper      <= OPER_RST;
         ctrl      <= CTRL_RST;
         clamp     <= CLAMP_RST;
         vga_gain  <= VGA_RST;
      end else begin
         wr_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (sl_fall) begin
                  bit_cnt <= '0;
                  shift_q <= '0;
               end
            end
            SHIFT: begin
               // A clock edge coinciding with the end of the frame is dropped.
               if (sck_rise && !sl_rise) begin
                  if (bit_cnt < CNT_GOOD) shift_q <= {sdata_s, shift_q[FRAME_W-1:1]};
                  if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
               end
            end
            CHECK: begin
               if (bit_cnt == CNT_GOOD) begin
                  wr_valid  <= 1'b1;
                  wr_addr   <= frame_addr;
                  wr_data   <= frame_data;
                  frame_cnt <= frame_cnt + 16'd1;
                  case (frame_addr)
                     ADDR_W'(ADDR_OPER):  oper     <= frame_data[OPER_W-1:0];
                     ADDR_W'(ADDR_CTRL):  ctrl     <= frame_data[CTRL_W-1:0];
                     ADDR_W'(ADDR_CLAMP): clamp    <= frame_data[CLAMP_W-1:0];
                     ADDR_W'(ADDR_VGA):   vga_gain <= frame_data[VGA_W-1:0];
                     default: ;
                  endcase
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
